// File: rtl/down_counter_load_pkg.sv
// Shared definitions for the loadable down counter: default width and the run-state encoding.
package down_counter_load_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/down_counter_load_if.sv
// Control and status bundle between the timer's owner (master) and the counter (slave).
interface down_counter_load_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             auto_reload;
    logic [WIDTH-1:0] count_contents;
    logic             terminal_count;
    logic             busy;

    modport master (
        output enable, load, load_value, auto_reload,
        input  count_contents, terminal_count, busy
    );

    modport slave (
        input  enable, load, load_value, auto_reload,
        output count_contents, terminal_count, busy
    );
endinterface

// File: rtl/down_counter_load_tff_load_cell.sv
// One counter bit: a T flip-flop with a parallel-load D input; clear beats load beats toggle.
module tff_load_cell (
    input  logic clk,
    input  logic clear,
    input  logic t,
    input  logic load,
    input  logic d,
    output logic q
);
    logic q_reg;

    always_ff @(posedge clk) begin
        if (!clear) begin
            q_reg <= 1'b0;
        end else if (load) begin
            q_reg <= d;
        end else if (t) begin
            q_reg <= ~q_reg;
        end
    end

    assign q = q_reg;
endmodule

// File: rtl/down_counter_load.sv
// Loadable, enable-gated down counter/timer with a one-cycle terminal-count pulse and optional auto-reload.
module down_counter_load
    import down_counter_load_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                clear,
    down_counter_load_if.slave  bus
);
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] cell_d;
    logic [WIDTH-1:0] zero_below;
    logic             dec;
    logic             terminal;
    logic             reload_now;
    logic             cell_load;
    logic             tc_reg;
    logic             busy_reg;
    state_t           state_reg;

    assign dec        = (state_reg == ST_RUN) && bus.enable;
    assign terminal   = dec && (count == WIDTH'(1));
    assign reload_now = terminal && bus.auto_reload;
    // An auto-reload at terminal count reuses the cells' parallel-load path.
    assign cell_load  = bus.load || reload_now;
    assign cell_d     = bus.load ? bus.load_value : reload_reg;

    // Borrow chain: a bit toggles when every bit below it is zero.
    assign zero_below[0] = 1'b1;

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_borrow
            assign zero_below[gi] = zero_below[gi-1] & ~count[gi-1];
        end

        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            tff_load_cell u_cell (
                .clk   (clk),
                .clear (clear),
                .t     (dec & zero_below[gi]),
                .load  (cell_load),
                .d     (cell_d[gi]),
                .q     (count[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!clear) begin
            state_reg  <= ST_IDLE;
            reload_reg <= '0;
            tc_reg     <= 1'b0;
            busy_reg   <= 1'b0;
        end else if (bus.load) begin
            reload_reg <= bus.load_value;
            tc_reg     <= 1'b0;
            if (bus.load_value != '0) begin
                state_reg <= ST_RUN;
                busy_reg  <= 1'b1;
            end else begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
            end
        end else begin
            tc_reg <= 1'b0;
            case (state_reg)
                ST_RUN: begin
                    if (terminal) begin
                        tc_reg <= 1'b1;
                        if (!bus.auto_reload) begin
                            state_reg <= ST_DONE;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
                ST_IDLE, ST_DONE: begin
                    busy_reg <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count_contents = count;
    assign bus.terminal_count = tc_reg;
    assign bus.busy           = busy_reg;
endmodule

// File: tb/tb_down_counter_load.sv
// Directed bench for down_counter_load: a behavioural timer model checked every cycle plus literal expectations.
module tb_down_counter_load;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic clear;

    down_counter_load_if #(.WIDTH(WIDTH)) bus ();

    down_counter_load #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    // Behavioural model: the timer's rules written directly as integer arithmetic.
    int m_count  = 0;
    int m_reload = 0;
    int m_mode   = 0;   // 0 idle, 1 running, 2 finished
    int m_tc     = 0;

    always @(posedge clk) begin
        if (!clear) begin
            m_count = 0; m_reload = 0; m_mode = 0; m_tc = 0;
        end else if (bus.load) begin
            m_count  = int'(bus.load_value);
            m_reload = m_count;
            m_tc     = 0;
            m_mode   = (m_count != 0) ? 1 : 0;
        end else if (m_mode == 1 && bus.enable) begin
            if (m_count == 1) begin
                m_tc = 1;
                if (bus.auto_reload) m_count = m_reload;
                else begin m_count = 0; m_mode = 2; end
            end else begin
                m_count = m_count - 1;
                m_tc    = 0;
            end
        end else begin
            m_tc = 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_count", int'(bus.count_contents), m_count);
            chk("model_tc",    int'(bus.terminal_count), m_tc);
            chk("model_busy",  int'(bus.busy),           (m_mode == 1) ? 1 : 0);
        end
    end

    task automatic step(input logic clr, input logic en, input logic ld,
                        input logic [7:0] lv, input logic ar);
        clear           = clr;
        bus.enable      = en;
        bus.load        = ld;
        bus.load_value  = lv;
        bus.auto_reload = ar;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lit(input string name, input int c, input int tc, input int b);
        chk({name, "_count"}, int'(bus.count_contents), c);
        chk({name, "_tc"},    int'(bus.terminal_count), tc);
        chk({name, "_busy"},  int'(bus.busy),           b);
        $display("step %s: count=%0d tc=%0b busy=%0b", name,
                 bus.count_contents, bus.terminal_count, bus.busy);
    endtask

    initial begin
        int exp_c2 [5] = '{4, 3, 2, 1, 0};
        int exp_c3 [6] = '{2, 1, 3, 2, 1, 3};
        int exp_c4 [7] = '{3, 3, 2, 2, 1, 1, 0};
        int tc_total;

        clear = 1'b0; bus.enable = 1'b0; bus.load = 1'b0;
        bus.load_value = '0; bus.auto_reload = 1'b0;
        @(negedge clk);

        // 1: clear beats load; enable ignored while idle
        step(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0);
        chk_en = 1'b1;
        step(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0);
        lit("clear", 0, 0, 0);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        lit("idle_en", 0, 0, 0);

        // 2: one-shot from 5
        step(1'b1, 1'b1, 1'b1, 8'd5, 1'b0);
        lit("load5", 5, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
            lit("oneshot", exp_c2[i], (i == 4) ? 1 : 0, (i == 4) ? 0 : 1);
        end
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        lit("done_hold", 0, 0, 0);

        // 3: auto-reload from 3
        step(1'b1, 1'b1, 1'b1, 8'd3, 1'b1);
        lit("load3", 3, 0, 1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
            lit("reload", exp_c3[i], (exp_c3[i] == 3) ? 1 : 0, 1);
        end

        // 4: enable alternating, one pulse total
        step(1'b1, 1'b0, 1'b1, 8'd4, 1'b0);
        lit("load4", 4, 0, 1);
        tc_total = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, (i % 2 == 0), 1'b0, 8'h00, 1'b0);
            tc_total += int'(bus.terminal_count);
            lit("alt", exp_c4[i], (i == 6) ? 1 : 0, (i == 6) ? 0 : 1);
        end
        chk("alt_tc_total", tc_total, 1);

        // 5: zero load never runs
        step(1'b1, 1'b1, 1'b1, 8'd0, 1'b0);
        tc_total = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
            tc_total += int'(bus.terminal_count);
        end
        lit("zero_load", 0, 0, 0);
        chk("zero_tc_total", tc_total, 0);

        // 6a: clear mid-run aborts without a pulse
        step(1'b1, 1'b0, 1'b1, 8'd3, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        lit("pre_abort", 2, 0, 1);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        lit("abort_clear", 0, 0, 0);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        lit("abort_idle", 0, 0, 0);

        // 6b: load beats the terminal edge
        step(1'b1, 1'b0, 1'b1, 8'd2, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        lit("pre_reload", 1, 0, 1);
        step(1'b1, 1'b1, 1'b1, 8'd9, 1'b0);
        lit("load_beats_tc", 9, 0, 1);

        // Borrow propagation across several bits
        step(1'b1, 1'b0, 1'b1, 8'h80, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        lit("borrow_80", 8'h7F, 0, 1);
        step(1'b1, 1'b0, 1'b1, 8'h10, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        lit("borrow_10", 8'h0F, 0, 1);

        // Reload value of 1 pulses on every enabled edge
        step(1'b1, 1'b0, 1'b1, 8'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
            lit("reload1", 1, 1, 1);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
